mem_responder: RTL and testbench

Byte-addressed data memory that answers the CPU's memory interface: it is the responder end of the MOV/MFA handshake the datapath control unit initiates when it reads or writes data through its 32-bit registers. It accepts one request at a time, waits a fixed access latency, then performs the read or write and raises MFA until the initiator drops MOV. It supports byte, halfword and word transfers in big-endian order.

---
 rtl/mem_responder.sv | 123 ++++++++++++
 tb/tb_mem_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-addressed big-endian data memory answering the MOV/MFA handshake
// One request in flight; access happens LATENCY edges after acceptance, then MFA holds until MOV drops.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              mov,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              mfa,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              lat_rw;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_data;

  logic              do_access;
  logic              acc_rw;
  logic [1:0]        acc_size;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_data;
  logic [ADDR_W-1:0] w_b0, w_b1, w_b2, w_b3, h_b0, h_b1;
  logic [31:0]       rd_val;

  logic [7:0]        mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mov) state_nxt = (LATENCY == 1) ? S_DONE : S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_DONE;
      S_DONE:  if (!mov) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mfa  = (state == S_DONE);
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= 4'd0;
    end else if (state == S_IDLE && mov) begin
      cnt      <= 4'(LATENCY - 1);
      lat_rw   <= rw;
      lat_size <= size;
      lat_addr <= addr;
      lat_data <= data_in;
    end else if (state == S_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // With LATENCY=1 the access happens on the accepting edge, so it must use the live inputs.
  always_comb begin
    do_access = (state == S_WAIT && cnt == 4'd0) ||
                (LATENCY == 1 && state == S_IDLE && mov);
    acc_rw    = (state == S_IDLE) ? rw      : lat_rw;
    acc_size  = (state == S_IDLE) ? size    : lat_size;
    acc_addr  = (state == S_IDLE) ? addr    : lat_addr;
    acc_data  = (state == S_IDLE) ? data_in : lat_data;
  end

  always_comb begin
    w_b0 = {acc_addr[ADDR_W-1:2], 2'b00};
    w_b1 = {acc_addr[ADDR_W-1:2], 2'b01};
    w_b2 = {acc_addr[ADDR_W-1:2], 2'b10};
    w_b3 = {acc_addr[ADDR_W-1:2], 2'b11};
    h_b0 = {acc_addr[ADDR_W-1:1], 1'b0};
    h_b1 = {acc_addr[ADDR_W-1:1], 1'b1};
  end

  always_comb begin
    case (acc_size)
      2'b00:   rd_val = {24'h0, mem[acc_addr]};
      2'b01:   rd_val = {16'h0, mem[h_b0], mem[h_b1]};
      default: rd_val = {mem[w_b0], mem[w_b1], mem[w_b2], mem[w_b3]};
    endcase
  end

  // Memory contents survive clr, but a clr on the completion edge cancels the write.
  always_ff @(posedge clk) begin
    if (!clr && do_access && !acc_rw) begin
      case (acc_size)
        2'b00: mem[acc_addr] <= acc_data[7:0];
        2'b01: begin
          mem[h_b0] <= acc_data[15:8];
          mem[h_b1] <= acc_data[7:0];
        end
        default: begin
          mem[w_b0] <= acc_data[31:24];
          mem[w_b1] <= acc_data[23:16];
          mem[w_b2] <= acc_data[15:8];
          mem[w_b3] <= acc_data[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr)                      data_out <= 32'h0;
    else if (do_access && acc_rw) data_out <= rd_val;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
// Table vectors, hand-written handshake corner cases and random traffic against a byte-array model.
module tb_mem_responder;
  localparam int ADDR_W  = 8;
  localparam int LATENCY = 3;

  logic        clk = 1'b0;
  logic        clr, mov, rw;
  logic [1:0]  size;
  logic [7:0]  addr;
  logic [31:0] data_in, data_out;
  logic        mfa, busy;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] last_rd = 32'h0;
  logic [7:0]  mdl [256];

  mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .clr(clr), .mov(mov), .rw(rw), .size(size), .addr(addr),
    .data_in(data_in), .data_out(data_out), .mfa(mfa), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] sz, input logic [7:0] a);
    int n    = nbytes(sz);
    int base = int'(a) - (int'(a) % n);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(mdl[base + i]);
    return v;
  endfunction

  function automatic void model_write(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] d);
    int n    = nbytes(sz);
    int base = int'(a) - (int'(a) % n);
    for (int i = 0; i < n; i++) mdl[base + i] = 8'(d >> (8 * (n - 1 - i)));
  endfunction

  // Called at a negedge with the DUT idle; drives a request and completes the handshake.
  task automatic txn(input logic r, input logic [1:0] sz, input logic [7:0] a,
                     input logic [31:0] d, input int hold, input logic [31:0] exp, input string tag);
    int   edges = 0;
    logic got   = 1'b0;
    logic [31:0] want = r ? exp : last_rd;
    mov = 1'b1; rw = r; size = sz; addr = a; data_in = d;
    while (edges < 40 && !got) begin
      @(negedge clk);
      edges++;
      if (edges == 1) chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
      if (mfa) got = 1'b1;
    end
    chk({tag, " mfa_latency"}, edges, LATENCY + 1);
    chk({tag, " data_out"}, data_out, want);
    for (int i = 0; i < hold; i++) begin
      rw = ~rw; addr = 8'($urandom); data_in = $urandom;
      @(negedge clk);
      chk({tag, " hold_mfa"}, 32'(mfa), 32'd1);
      chk({tag, " hold_data"}, data_out, want);
    end
    mov = 1'b0;
    @(negedge clk);
    chk({tag, " mfa_drop"}, 32'(mfa), 32'd0);
    chk({tag, " busy_drop"}, 32'(busy), 32'd0);
    if (r) last_rd = exp;
  endtask

  vec_t vecs[12];

  initial begin
    int hi;
    vecs[0]  = '{1'b0, 2'd2, 8'h10, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, 2'd2, 8'h10, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 2'd0, 8'h10, 32'h0,        32'h000000DE};
    vecs[3]  = '{1'b1, 2'd0, 8'h13, 32'h0,        32'h000000EF};
    vecs[4]  = '{1'b0, 2'd0, 8'h11, 32'hFFFFFF55, 32'h0};
    vecs[5]  = '{1'b0, 2'd1, 8'h13, 32'hABCD1234, 32'h0};
    vecs[6]  = '{1'b1, 2'd2, 8'h10, 32'h0,        32'hDE551234};
    vecs[7]  = '{1'b1, 2'd1, 8'h11, 32'h0,        32'h0000DE55};
    vecs[8]  = '{1'b1, 2'd3, 8'h12, 32'h0,        32'hDE551234};
    vecs[9]  = '{1'b0, 2'd3, 8'h17, 32'h0A0B0C0D, 32'h0};
    vecs[10] = '{1'b1, 2'd0, 8'h15, 32'h0,        32'h0000000B};
    vecs[11] = '{1'b1, 2'd1, 8'h16, 32'h0,        32'h00000C0D};

    clr = 1'b1; mov = 1'b1; rw = 1'b0; size = 2'd2; addr = 8'h20; data_in = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset mfa", 32'(mfa), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset data_out", data_out, 32'h0);
    clr = 1'b0;
    txn(1'b0, 2'd2, 8'h20, 32'h0, 0, 32'h0, "post_reset_write");

    foreach (vecs[i])
      txn(vecs[i].rw, vecs[i].size, vecs[i].addr, vecs[i].wdata, 0, vecs[i].exp,
          $sformatf("vec%0d", i));

    txn(1'b1, 2'd2, 8'h10, 32'h0, 5, 32'hDE551234, "hold5");

    // Early drop: mov high for the accepting edge only.
    mov = 1'b1; rw = 1'b0; size = 2'd0; addr = 8'h25; data_in = 32'h00000077;
    @(negedge clk);
    mov = 1'b0;
    chk("early busy", 32'(busy), 32'd1);
    hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (mfa) hi++;
    end
    chk("early mfa_pulse_count", hi, 1);
    chk("early busy_end", 32'(busy), 32'd0);
    txn(1'b1, 2'd0, 8'h25, 32'h0, 0, 32'h00000077, "early_readback");

    // clr asserted on the completion edge of a write.
    mov = 1'b1; rw = 1'b0; size = 2'd2; addr = 8'h20; data_in = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    clr = 1'b1; mov = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    hi = 0;
    chk("midclr data_out", data_out, 32'h0);
    chk("midclr busy", 32'(busy), 32'd0);
    repeat (4) begin
      @(negedge clk);
      if (mfa) hi++;
    end
    chk("midclr no_mfa", hi, 0);
    last_rd = 32'h0;
    txn(1'b1, 2'd2, 8'h20, 32'h0, 0, 32'h00000000, "midclr_readback");

    for (int a = 8'h40; a < 8'h80; a += 4) begin
      logic [31:0] d = $urandom;
      model_write(2'd2, 8'(a), d);
      txn(1'b0, 2'd2, 8'(a), d, 0, 32'h0, "preload");
    end
    for (int k = 0; k < 40; k++) begin
      logic        r  = 1'($urandom_range(0, 1));
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [7:0]  a  = 8'($urandom_range(8'h40, 8'h7F));
      logic [31:0] d  = $urandom;
      logic [31:0] e  = 32'h0;
      if (r) e = model_read(sz, a);
      else   model_write(sz, a, d);
      txn(r, sz, a, d, k % 3, e, $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
